// File: rtl/sccb_master_pkg.sv
// Shared definitions for the SCCB write master.
// Holds the FSM state encoding, the frame timing constants and a helper that
// assembles the 27-slot serial frame (three bytes, each followed by an ack slot).
package sccb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BITS  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int QUARTERS    = 4;
  localparam int SLOTS       = 27;
  localparam int START_TICKS = 2;
  localparam int STOP_TICKS  = 3;

  localparam logic [1:0] Q_LAST     = 2'(QUARTERS - 1);
  localparam logic [4:0] SLOT_LAST  = 5'(SLOTS - 1);
  localparam logic [1:0] START_LAST = 2'(START_TICKS - 1);
  // Quarter-counter value parked in STOP once the last STOP tick has been issued.
  localparam logic [1:0] STOP_DONE  = 2'(STOP_TICKS);

  // Ack slots sit after each byte; a 1 in this mask marks them.
  localparam logic [26:0] ACK_MASK = {8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};

  // Serial frame, MSB first; ack slot positions carry 1 (bus released).
  function automatic logic [26:0] frame_bits(input logic [7:0] id,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
    return {id, 1'b1, addr, 1'b1, data, 1'b1};
  endfunction

endpackage

// File: rtl/sccb_master_shifter.sv
// sccb_shifter: 27-bit loadable shift register for the SCCB frame.
// Ports:
//   clk     - system clock
//   load    - load a new frame from id/addr/data
//   shift   - advance to the next slot
//   id/addr/data - bytes of the frame
//   bit_out - value of the current slot (MSB of the register)
//   is_ack  - current slot is an ack slot
module sccb_shifter
  import sccb_master_pkg::*;
(
  input  logic       clk,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] id,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       bit_out,
  output logic       is_ack
);

  logic [26:0] bits_r;
  logic [26:0] mask_r;

  // Frame and ack-marker registers; loaded on accept, shifted once per slot.
  always_ff @(posedge clk) begin
    if (load) begin
      bits_r <= frame_bits(id, addr, data);
      mask_r <= ACK_MASK;
    end else if (shift) begin
      bits_r <= {bits_r[25:0], 1'b1};
      mask_r <= {mask_r[25:0], 1'b0};
    end
  end

  assign bit_out = bits_r[26];
  assign is_ack  = mask_r[26];

endmodule

// File: rtl/sccb_master.sv
// sccb_master: three-phase SCCB write master (ID, sub-address, data).
// Ports:
//   CLK     - system clock, rising edge
//   RST     - synchronous active-high reset
//   iTICK   - quarter-SCL-period enable pulse
//   iSTART  - transfer request, accepted only when idle
//   iID/iADDR/iDATA - bytes sent MSB first, each followed by an ack slot
//   iSDA    - SDA pad level, sampled in ack slots
//   oSCL    - SCL level
//   oSDA_OE - 1 pulls SDA low, 0 releases it
//   oBUSY   - transfer in progress
//   oDONE   - one-cycle completion pulse
//   oNACK   - some ack slot of the last transfer saw SDA high
// Parameter STOP_ON_NACK: a NACK jumps straight to STOP after its ack slot.
module sccb_master
  import sccb_master_pkg::*;
#(
  parameter bit STOP_ON_NACK = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iTICK,
  input  logic       iSTART,
  input  logic [7:0] iID,
  input  logic [7:0] iADDR,
  input  logic [7:0] iDATA,
  input  logic       iSDA,
  output logic       oSCL,
  output logic       oSDA_OE,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oNACK
);

  state_t     state_r, state_nxt_s;
  logic [1:0] q_r, q_nxt_s;
  logic [4:0] slot_r, slot_nxt_s;
  logic       scl_r, scl_nxt_s;
  logic       oe_r, oe_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       done_r, done_nxt_s;
  logic       nack_r, nack_nxt_s;
  logic       load_s, shift_s;
  logic       bit_s, is_ack_s;

  sccb_shifter u_shifter (
    .clk     (CLK),
    .load    (load_s),
    .shift   (shift_s),
    .id      (iID),
    .addr    (iADDR),
    .data    (iDATA),
    .bit_out (bit_s),
    .is_ack  (is_ack_s)
  );

  // State, counters and registered bus/status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      q_r     <= 2'd0;
      slot_r  <= 5'd0;
      scl_r   <= 1'b1;
      oe_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      nack_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      q_r     <= q_nxt_s;
      slot_r  <= slot_nxt_s;
      scl_r   <= scl_nxt_s;
      oe_r    <= oe_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      nack_r  <= nack_nxt_s;
    end
  end

  // Next-state and next-output logic; outside IDLE everything waits for iTICK
  // except the final STOP-to-IDLE step, which happens on the very next CLK.
  always_comb begin
    state_nxt_s = state_r;
    q_nxt_s     = q_r;
    slot_nxt_s  = slot_r;
    scl_nxt_s   = scl_r;
    oe_nxt_s    = oe_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    nack_nxt_s  = nack_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        scl_nxt_s  = 1'b1;
        oe_nxt_s   = 1'b0;
        busy_nxt_s = 1'b0;
        q_nxt_s    = 2'd0;
        slot_nxt_s = 5'd0;
        if (iSTART) begin
          load_s      = 1'b1;
          busy_nxt_s  = 1'b1;
          nack_nxt_s  = 1'b0;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (iTICK) begin
          if (q_r == START_LAST) begin
            scl_nxt_s   = 1'b0;
            q_nxt_s     = 2'd0;
            slot_nxt_s  = 5'd0;
            state_nxt_s = ST_BITS;
          end else begin
            // SDA falls while SCL is still high: the START condition.
            scl_nxt_s = 1'b1;
            oe_nxt_s  = 1'b1;
            q_nxt_s   = q_r + 2'd1;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_BITS: begin
        if (iTICK) begin
          case (q_r)
            2'd0: begin
              // SDA only moves here, while SCL is low.
              scl_nxt_s = 1'b0;
              oe_nxt_s  = is_ack_s ? 1'b0 : ~bit_s;
              q_nxt_s   = 2'd1;
            end
            2'd1: begin
              scl_nxt_s = 1'b1;
              q_nxt_s   = 2'd2;
            end
            2'd2: begin
              scl_nxt_s = 1'b1;
              if (is_ack_s && iSDA) begin
                nack_nxt_s = 1'b1;
              end else begin
                nack_nxt_s = nack_r;
              end
              q_nxt_s = Q_LAST;
            end
            default: begin
              scl_nxt_s = 1'b0;
              q_nxt_s   = 2'd0;
              // nack_r already reflects this slot's sample taken at q2.
              if ((slot_r == SLOT_LAST) || (STOP_ON_NACK && is_ack_s && nack_r)) begin
                state_nxt_s = ST_STOP;
              end else begin
                slot_nxt_s = slot_r + 5'd1;
                shift_s    = 1'b1;
              end
            end
          endcase
        end else begin
          state_nxt_s = ST_BITS;
        end
      end
      ST_STOP: begin
        if (q_r == STOP_DONE) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          q_nxt_s     = 2'd0;
        end else if (iTICK) begin
          case (q_r)
            2'd0: begin
              scl_nxt_s = 1'b0;
              oe_nxt_s  = 1'b1;
              q_nxt_s   = 2'd1;
            end
            2'd1: begin
              scl_nxt_s = 1'b1;
              q_nxt_s   = 2'd2;
            end
            default: begin
              // SDA rises while SCL is high: the STOP condition.
              oe_nxt_s = 1'b0;
              q_nxt_s  = STOP_DONE;
            end
          endcase
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign oSCL    = scl_r;
  assign oSDA_OE = oe_r;
  assign oBUSY   = busy_r;
  assign oDONE   = done_r;
  assign oNACK   = nack_r;

endmodule

// File: doc/sccb_master.md
SCCB_MASTER -- requirements
Module: sccb_master

Interface
REQ-001 Parameter STOP_ON_NACK, default 0: when 1, a sampled NACK in any ack slot aborts the transfer straight to STOP.
REQ-002 CLK  input  1  system clock; all logic is on the rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 iTICK  input  1  one-CLK enable pulse from the clock-divider stage; one tick is one quarter SCL period.
REQ-005 iSTART  input  1  transfer request; sampled every CLK.
REQ-006 iID  input  8  slave ID byte, including the write bit in bit 0.
REQ-007 iADDR  input  8  sub-address byte.
REQ-008 iDATA  input  8  data byte.
REQ-009 iSDA  input  1  SDA pad level, for ack sampling.
REQ-010 oSCL  output  1  SCL level.
REQ-011 oSDA_OE  output  1  1 drives SDA low; 0 releases SDA to the pull-up.
REQ-012 oBUSY  output  1  transfer in progress.
REQ-013 oDONE  output  1  one-CLK completion pulse.
REQ-014 oNACK  output  1  at least one ack slot of the last transfer sampled iSDA=1; holds until the next accepted start.

Function
REQ-015 Accept: iSTART=1 while oBUSY=0 latches iID, iADDR and iDATA and sets oBUSY=1 on the next CLK; iSTART while oBUSY=1 is ignored.
REQ-016 Tick gating: after accept, every state advance happens only on CLK cycles with iTICK=1; an iTICK coincident with the accepting iSTART is not counted.
REQ-017 States: IDLE -> START -> BITS -> STOP -> IDLE.
REQ-018 START, tick 1: oSDA_OE=1 while oSCL=1.
REQ-019 START, tick 2: oSCL=0.
REQ-020 BITS: 27 bit slots in order ID[7:0], ack, ADDR[7:0], ack, DATA[7:0], ack; MSB first.
REQ-021 Each bit slot is 4 ticks (q0..q3):
- q0: oSCL=0; oSDA_OE = NOT bit (ack slot: oSDA_OE=0).
- q1: oSCL=1.
- q2: oSCL=1; in an ack slot, sample iSDA.
- q3: oSCL=0.
REQ-022 oSDA_OE changes only at q0 or in START/STOP, never while oSCL=1 inside BITS.
REQ-023 STOP, tick 1: oSCL=0, oSDA_OE=1.
REQ-024 STOP, tick 2: oSCL=1.
REQ-025 STOP, tick 3: oSDA_OE=0.
REQ-026 Completion: on the CLK after the STOP tick-3 edge, the block returns to IDLE with oBUSY=0 and oDONE=1 for exactly that one cycle.
REQ-027 Full transfer length: 2+108+3 = 113 ticks.
REQ-028 NACK: any ack-slot sample with iSDA=1 sets oNACK.
REQ-029 With STOP_ON_NACK=1, the tick after that ack slot's q3 is STOP tick 1.
REQ-030 With STOP_ON_NACK=0, a NACK does not alter sequencing.
REQ-031 oNACK clears on accept.
REQ-032 Counters: 2-bit quarter counter; 5-bit slot counter, range 0..26, with no wrap beyond 26.
REQ-033 In IDLE: oSCL=1, oSDA_OE=0.

Reset
REQ-034 RST=1 forces state IDLE and counters 0.
REQ-035 Reset values: oSCL=1, oSDA_OE=0, oBUSY=0, oDONE=0, oNACK=0.
REQ-036 The reset values appear on the CLK edge that samples RST=1, including mid-transfer; the bus is released without a STOP and no oDONE is issued.
REQ-037 Latched bytes need no reset.

Structure
REQ-038 Shared package/include holds: state encodings; QUARTERS=4; SLOTS=27; START_TICKS=2; STOP_TICKS=3.
REQ-039 One sub-module is natural: sccb_shifter, a 27-bit loadable shift register that presents the current slot bit and flags ack slots.
REQ-040 The remainder is one FSM with registered outputs.

Verification
REQ-041 Write: iID=0x42, iADDR=0x12, iDATA=0x80, iSDA tied 0, iTICK every 4 CLK.
- Response: SDA bit stream 0100_0010 Z 0001_0010 Z 1000_0000 Z.
- Exactly 113 ticks from the first counted tick to the STOP release.
- oDONE one cycle; oNACK=0.
REQ-042 Busy: iSTART pulsed again at tick 50 -> ignored; a single 113-tick transfer results.
REQ-043 NACK with STOP_ON_NACK=0: iSDA=1 during the second ack slot -> oNACK=1 at completion; still 113 ticks.
REQ-044 NACK with STOP_ON_NACK=1: iSDA=1 in the first ack slot -> STOP follows immediately; 2+36+3=41 ticks; oDONE pulses; oNACK=1.
REQ-045 Reset mid-operation: RST=1 for one CLK at tick 70 -> next edge shows oSCL=1, oSDA_OE=0, oBUSY=0 and no oDONE; a new iSTART afterwards completes normally.
REQ-046 Bus protocol: the checker flags any oSDA_OE change while oSCL=1 outside START/STOP, and iTICK held 0 for 1000 CLK -> outputs frozen.
